// File: rtl/apb_initiator_pkg.sv
// Shared types and constants for the APB initiator.
// FSM state encoding and the default timeout length.
package apb_initiator_pkg;

    localparam int APB_INIT_DEFAULT_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_init_state_e;

endpackage

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator bridging a req/gnt port to APB.
// Optional ACCESS timeout enabled by defining APB_INITIATOR_TIMEOUT_EN.
module apb_initiator
    import apb_initiator_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = APB_INIT_DEFAULT_TIMEOUT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    apb_init_state_e state_q, state_d;

    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic we_q;
    logic rvalid_q;
    logic err_q;

    logic in_idle;
    logic in_access;
    logic tout;
    logic done;

    assign in_idle   = (state_q == IDLE);
    assign in_access = (state_q == ACCESS);
    assign gnt_o     = in_idle & req_i;

`ifdef APB_INITIATOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    // A ready on the would-be timeout cycle wins over the timeout.
    assign tout = in_access & ~pready_i
                & ((cnt_q + CW'(1)) == CNT_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (gnt_o) begin
            cnt_q <= '0;
        end else if (in_access && !pready_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
`else
    assign tout = 1'b0;
`endif

    assign done = in_access & (pready_i | tout);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_i) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_o) begin
                addr_q  <= addr_i;
                we_q    <= we_i;
                wdata_q <= wdata_i;
            end
            rvalid_q <= done;
            err_q    <= tout | (done & pslverr_i);
            // Writes and timeouts return zero data.
            if (done && pready_i && !we_q) begin
                rdata_q <= prdata_i;
            end else begin
                rdata_q <= '0;
            end
        end
    end

    assign psel_o    = ~in_idle;
    assign penable_o = in_access;
    assign pwrite_o  = ~in_idle & we_q;
    assign paddr_o   = in_idle ? '0 : addr_q;
    assign pwdata_o  = in_idle ? '0 : wdata_q;

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Randomized self-checking bench for apb_initiator.
// Expected behaviour is derived from per-transaction cycle arithmetic.
module tb_apb_initiator;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    apb_initiator #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .gnt_o    (gnt),
        .addr_i   (addr),
        .we_i     (we),
        .wdata_i  (wdata),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .psel_o   (psel),
        .penable_o(penable),
        .pwrite_o (pwrite),
        .paddr_o  (paddr),
        .pwdata_o (pwdata),
        .prdata_i (prdata),
        .pready_i (pready),
        .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({rvalid, err, rdata, psel, penable, pwrite, paddr, pwdata, gnt}
            !== '0) begin
            errors++;
            $display("FAIL reset: rv=%b err=%b rd=%h sel=%b en=%b wr=%b a=%h wd=%h gnt=%b, want all 0",
                     rvalid, err, rdata, psel, penable, pwrite, paddr, pwdata, gnt);
        end
        tick();
        rst = 1'b0;
    endtask

    // One full transaction; waits = pready-low ACCESS cycles before ready.
    task automatic do_txn(input string nm, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input int waits,
                          input logic [31:0] rd, input logic se);
        bit          to;
        int          n_acc;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [68:0] obs, exp;
        to = 1'b0;
`ifdef APB_INITIATOR_TIMEOUT_EN
        to = (waits >= TO);
`endif
        n_acc   = to ? TO : waits + 1;
        exp_err = to ? 1'b1 : se;
        exp_rd  = (to || w) ? 32'h0 : rd;

        req = 1'b1; addr = a; we = w; wdata = d;
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
        @(negedge clk);
        checks++;
        if (gnt !== 1'b1 || psel !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s grant: gnt=%b sel=%b rv=%b, want 1 0 0",
                     nm, gnt, psel, rvalid);
        end
        tick();

        // SETUP then ACCESS cycles, with junk on the ignored inputs.
        for (int i = -1; i < n_acc; i++) begin
            req = 1'($urandom); addr = $urandom; we = 1'($urandom);
            wdata = $urandom;
            if (i >= 0 && !to && i == n_acc - 1) begin
                pready = 1'b1; prdata = rd; pslverr = se;
            end else begin
                pready = (i < 0) ? 1'($urandom) : 1'b0;
                prdata = $urandom; pslverr = 1'($urandom);
            end
            @(negedge clk);
            obs = {gnt, psel, penable, pwrite, paddr, pwdata, rvalid};
            exp = {1'b0, 1'b1, (i >= 0), w, a, d, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cyc%0d apb: got %h want %h", nm, i, obs, exp);
            end
            tick();
        end

        req = 1'b0; pready = 1'($urandom); prdata = $urandom;
        pslverr = 1'($urandom);
        @(negedge clk);
        obs = {gnt, psel, penable, pwrite, paddr, pwdata, rvalid};
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
        checks++;
        if (obs !== exp || err !== exp_err || rdata !== exp_rd) begin
            errors++;
            $display("FAIL %s resp: bus %h want %h err=%b want %b rd=%h want %h",
                     nm, obs, exp, err, exp_err, rdata, exp_rd);
        end
        tick();

        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s post: rv=%b err=%b rd=%h want 0 0 0",
                     nm, rvalid, err, rdata);
        end
        tick();
    endtask

    task automatic test_directed();
        do_txn("wr0ws", 32'h1A10_0004, 1'b1, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b0);
        do_txn("rd3ws", 32'h1A10_0008, 1'b0, 32'h5555_AAAA, 3, 32'h0000_CAFE, 1'b0);
        do_txn("slverr", 32'h1A10_000C, 1'b0, 32'h0, 1, 32'hFFFF_0001, 1'b1);
        do_txn("wrerr", 32'h0000_0010, 1'b1, 32'hA5A5_A5A5, 0, 32'h0, 1'b1);
    endtask

    task automatic test_timeout();
        do_txn("to_hit", 32'h2000_0000, 1'b0, 32'h0, 8, 32'h0BAD_F00D, 1'b0);
        do_txn("to_edge", 32'h2000_0004, 1'b0, 32'h0, TO - 1, 32'h600D_D00D, 1'b0);
        do_txn("to_exact", 32'h2000_0008, 1'b1, 32'h1, TO, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            do_txn("rand", $urandom, 1'($urandom), $urandom,
                   int'($urandom_range(0, 6)), $urandom, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        req = 1'b1; addr = 32'h3000_0000; we = 1'b0; wdata = '0;
        pready = 1'b0; pslverr = 1'b0;
        tick();
        req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b1) begin
            errors++;
            $display("FAIL rstmid pre: sel=%b en=%b want 1 1", psel, penable);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid post: sel=%b en=%b rv=%b want 0 0 0",
                     psel, penable, rvalid);
        end
        for (int i = 0; i < 8; i++) begin
            pready = 1'b1;
            tick();
            @(negedge clk);
            if (rvalid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rstmid rvalid: pulse seen=1 want 0");
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int g[4];
        int r[4];
        int ng = 0;
        int nr = 0;
        we = 1'b1; pslverr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            req = (ng < 2); addr = $urandom; wdata = $urandom; pready = 1'b1;
            @(negedge clk);
            if (gnt === 1'b1 && ng < 4) begin g[ng] = c; ng++; end
            if (rvalid === 1'b1 && nr < 4) begin r[nr] = c; nr++; end
            tick();
        end
        req = 1'b0;
        checks++;
        if (ng !== 2 || g[0] !== 0 || g[1] !== 3) begin
            errors++;
            $display("FAIL b2b grants: n=%0d at %0d,%0d want 2 at 0,3",
                     ng, g[0], g[1]);
        end
        checks++;
        if (nr !== 2 || r[0] !== 3 || r[1] !== 6) begin
            errors++;
            $display("FAIL b2b resps: n=%0d at %0d,%0d want 2 at 3,6",
                     nr, r[0], r[1]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, want completion");
        $fatal(1);
    end

endmodule
